// File: rtl/counter.sv
// counter: free-running event counter streamed MSB-first over a mode-0 serial link (cs/sclk/sdo).
// Define COUNTER_GRAY_EN to send gray(count) as the payload instead of the binary count.
module counter #(
    parameter int WIDTH      = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic cs,
    output logic sclk,
    output logic sdo
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_count, w_count, r_shift, w_shift, w_payload;
    logic [DW-1:0]    r_div, w_div;
    logic [GW-1:0]    r_gap, w_gap;
    logic [BW-1:0]    r_bit, w_bit;
    logic             w_cs, w_sclk, w_sdo;

`ifdef COUNTER_GRAY_EN
    assign w_payload = r_count ^ (r_count >> 1);
`else
    assign w_payload = r_count;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_gap   <= '0;
            r_bit   <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            r_count <= w_count;
            r_shift <= w_shift;
            r_div   <= w_div;
            r_gap   <= w_gap;
            r_bit   <= w_bit;
            cs      <= w_cs;
            sclk    <= w_sclk;
            sdo     <= w_sdo;
        end
    end

    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_shift = r_shift;
        w_div   = r_div;
        w_gap   = r_gap;
        w_bit   = r_bit;
        w_cs    = cs;
        w_sclk  = sclk;
        w_sdo   = sdo;
        case (r_state)
            IDLE: if (enable) begin
                w_state = SHIFT;
                w_shift = w_payload;
                w_cs    = 1'b0;
                w_sdo   = w_payload[WIDTH-1];
                w_bit   = '0;
                w_div   = '0;
            end
            SHIFT: if (r_div != DW'(CLK_DIV - 1)) begin
                w_div = r_div + 1'b1;
            end else begin
                w_div  = '0;
                w_sclk = ~sclk;
                // falling toggle: advance to the next bit or close the frame
                if (sclk) begin
                    w_bit = r_bit + 1'b1;
                    if (r_bit == BW'(WIDTH - 1)) begin
                        w_state = GAP;
                        w_cs    = 1'b1;
                        w_sdo   = 1'b0;
                        w_count = r_count + 1'b1;
                        w_gap   = '0;
                    end else begin
                        w_shift = r_shift << 1;
                        w_sdo   = r_shift[WIDTH-2];
                    end
                end
            end
            GAP: if (r_gap == GW'(GAP_CYCLES - 1)) w_state = IDLE;
                 else w_gap = r_gap + 1'b1;
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized directed checks of the serial counter against a frame-level reference model.
module tb_counter;
    localparam int AW = 16, AD = 2, AG = 4;
    localparam int BWID = 4, BD = 1, BG = 1;
    localparam int A_LOW = 2 * AW * AD;
    localparam int A_PER = A_LOW + AG + 1;
    localparam int B_LOW = 2 * BWID * BD;
    localparam int B_PER = B_LOW + BG + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable_a = 1'b0, enable_b = 1'b0;
    logic cs_a, sclk_a, sdo_a, cs_b, sclk_b, sdo_b;
    longint cyc = 0;
    int cmp = 0, mism = 0;

    typedef struct {
        int inst;
        int word;
        int low;
        int pulses;
        longint fall;
    } frame_t;
    frame_t q[$];

    counter #(.WIDTH(AW), .CLK_DIV(AD), .GAP_CYCLES(AG)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .cs(cs_a), .sclk(sclk_a), .sdo(sdo_a)
    );
    counter #(.WIDTH(BWID), .CLK_DIV(BD), .GAP_CYCLES(BG)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples sdo on each sclk rise and emits one record per completed frame.
    initial begin
        int in_f[2], wd[2], lw[2], pl[2];
        longint fl[2];
        logic [1:0] psc, csv, sclkv, sdov;
        in_f = '{0, 0};
        psc = '0;
        forever begin
            @(negedge clk);
            csv = {cs_b, cs_a};
            sclkv = {sclk_b, sclk_a};
            sdov = {sdo_b, sdo_a};
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    in_f[k] = 0;
                    psc[k] = 1'b0;
                end else begin
                    if (!csv[k] && in_f[k] == 0) begin
                        in_f[k] = 1; wd[k] = 0; lw[k] = 0; pl[k] = 0; fl[k] = cyc;
                    end
                    if (in_f[k] != 0) begin
                        if (csv[k]) begin
                            q.push_back('{k, wd[k], lw[k], pl[k], fl[k]});
                            in_f[k] = 0;
                        end else begin
                            lw[k]++;
                            if (sclkv[k] && !psc[k]) begin
                                wd[k] = (wd[k] << 1) | int'(sdov[k]);
                                pl[k]++;
                            end
                        end
                    end
                    psc[k] = sclkv[k];
                end
            end
        end
    end

    function automatic int payload(int v, int w);
        int b;
        b = v & ((1 << w) - 1);
`ifdef COUNTER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int max);
        int t = 0;
        while (q.size() < n && t < max) begin
            @(negedge clk);
            t++;
        end
        chk("frame_arrived", longint'(q.size() >= n), 1);
    endtask

    task automatic wait_cs_low(input int max);
        int t = 0;
        while (cs_a !== 1'b0 && t < max) begin
            @(negedge clk);
            t++;
        end
        chk("cs_fall_seen", longint'(cs_a === 1'b0), 1);
    endtask

    task automatic check_frame(input frame_t f, input int inst, input int val, input int w, input int low);
        chk("frame_inst", f.inst, inst);
        chk("frame_word", f.word, payload(val, w));
        chk("frame_cs_low_cycles", f.low, low);
        chk("frame_sclk_pulses", f.pulses, w);
    endtask

    initial begin
        int exp;
        frame_t f, p;
        exp = 0;
        // reset held with enable high: quiet bus
        enable_a = 1'b1;
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_cs_b", cs_b, 1);
        chk("rst_no_frames", q.size(), 0);
        enable_a = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_cs_high", cs_a, 1);
        end
        // back-to-back frames
        enable_a = 1'b1;
        wait_frames(3, 4 * A_PER);
        enable_a = 1'b0;
        for (int i = 0; i < 3 && q.size() > 0; i++) begin
            f = q.pop_front();
            check_frame(f, 0, exp, AW, A_LOW);
            if (i > 0) chk("frame_period", f.fall - p.fall, A_PER);
            p = f;
            exp++;
        end
        repeat (A_PER) @(negedge clk);
        q.delete();
        // randomized mid-frame enable drops
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            enable_a = 1'b1;
            wait_cs_low(5);
            repeat ($urandom_range(1, A_LOW - 4)) @(negedge clk);
            enable_a = 1'b0;
            wait_frames(1, 2 * A_PER);
            if (q.size() > 0) begin
                f = q.pop_front();
                check_frame(f, 0, exp, AW, A_LOW);
            end
            exp++;
            repeat ($urandom_range(10, 80)) @(negedge clk);
            chk("halt_no_new_frame", q.size(), 0);
            chk("halt_cs_high", cs_a, 1);
            q.delete();
        end
        // asynchronous reset in the middle of a frame
        enable_a = 1'b1;
        wait_cs_low(5);
        repeat ($urandom_range(5, A_LOW - 10)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs", cs_a, 1);
        chk("midrst_sclk", sclk_a, 0);
        chk("midrst_sdo", sdo_a, 0);
        @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        exp = 0;
        wait_frames(1, 2 * A_PER);
        enable_a = 1'b0;
        if (q.size() > 0) begin
            f = q.pop_front();
            check_frame(f, 0, exp, AW, A_LOW);
        end
        repeat (A_PER) @(negedge clk);
        q.delete();
        // narrow instance: wrap from all-ones back to zero
        enable_b = 1'b1;
        wait_frames(18, 20 * B_PER);
        enable_b = 1'b0;
        for (int k = 0; k < 18 && q.size() > 0; k++) begin
            f = q.pop_front();
            check_frame(f, 1, k, BWID, B_LOW);
            if (k > 0) chk("b_frame_period", f.fall - p.fall, B_PER);
            p = f;
        end
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
